pwm_shadow_regs: RTL

- Parametrised successor of the PCA9685-style register file. Holds the I2C-visible register map (MODE1, MODE2, per-channel LED bytes, ALL_LED, PRESCALE) for NUM_CH channels.
- Maintains an atomically updated shadow copy of each channel's 13-bit ON/OFF words for the PWM counter.
- New relative to the previous generation:
  - channel count is parametrised;
  - commit on STOP transfers only dirty channels;
  - a registered read port is added;
  - PRESCALE write-protection follows SLEEP;
  - each channel emits a commit pulse;
  - a write coinciding with STOP is handled deterministically.
- Sits between i2c_target (write/read/stop strobes) and the PWM counter bank.

---
 rtl/pwm_shadow_regs.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_shadow_regs.sv
// PCA9685-style register file with per-channel dirty tracking and shadow ON/OFF words.
// Writes land in one cycle; commits appear one cycle after the qualifying non-write cycle; no backpressure.
module pwm_shadow_regs #(
    parameter int          NUM_CH    = 16,
    parameter int          BASE_ADDR = 6,
    parameter logic [7:0]  ALL_ADDR  = 8'hFA,
    parameter logic [7:0]  PRE_ADDR  = 8'hFE,
    parameter logic [7:0]  PRE_RST   = 8'h1E
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [7:0]             wr_addr_i,
    input  logic [7:0]             wr_data_i,
    input  logic [7:0]             rd_addr_i,
    output logic [7:0]             rd_data_o,
    input  logic                   i2c_stop_i,
    output logic [7:0]             mode1_o,
    output logic [7:0]             mode2_o,
    output logic [7:0]             prescale_o,
    output logic [13*NUM_CH-1:0]   led_on_o,
    output logic [13*NUM_CH-1:0]   led_off_o,
    output logic [NUM_CH-1:0]      commit_o
);

    localparam int GEN_N = BASE_ADDR - 2;

    logic [7:0]        mode1_q, mode1_d, mode2_q, mode2_d, pre_q, pre_d;
    logic [7:0]        gen_q [GEN_N];
    logic [7:0]        gen_d [GEN_N];
    logic [7:0]        led_q [NUM_CH][4];
    logic [7:0]        led_d [NUM_CH][4];
    logic [3:0]        dirty_q [NUM_CH];
    logic [3:0]        dirty_d [NUM_CH];
    logic [12:0]       on_q [NUM_CH];
    logic [12:0]       on_d [NUM_CH];
    logic [12:0]       off_q [NUM_CH];
    logic [12:0]       off_d [NUM_CH];
    logic [NUM_CH-1:0] commit_q, commit_d;
    logic [7:0]        rd_q, rd_d;
    logic              stop_pend_q, stop_pend_d;
    logic              stop_now;

    always_comb begin
        mode1_d     = mode1_q;
        mode2_d     = mode2_q;
        pre_d       = pre_q;
        gen_d       = gen_q;
        led_d       = led_q;
        dirty_d     = dirty_q;
        on_d        = on_q;
        off_d       = off_q;
        commit_d    = '0;
        rd_d        = 8'h00;
        // A stop that collides with a write is deferred to the first non-write cycle
        stop_now    = (i2c_stop_i | stop_pend_q) & ~wr_en_i;
        stop_pend_d = (i2c_stop_i | stop_pend_q) & wr_en_i;

        if (!wr_en_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (mode2_q[3] ? (&dirty_q[n]) : (stop_now && (|dirty_q[n]))) begin
                    on_d[n]     = {led_q[n][1][4:0], led_q[n][0]};
                    off_d[n]    = {led_q[n][3][4:0], led_q[n][2]};
                    dirty_d[n]  = 4'b0000;
                    commit_d[n] = 1'b1;
                end
            end
            if (|commit_d) begin
                mode1_d[7] = 1'b0;
            end
        end else begin
            if (wr_addr_i == 8'h00) mode1_d = wr_data_i;
            if (wr_addr_i == 8'h01) mode2_d = wr_data_i;
            if (wr_addr_i == PRE_ADDR && mode1_q[4]) pre_d = wr_data_i;
            for (int i = 0; i < GEN_N; i++) begin
                if (wr_addr_i == 8'(i + 2)) gen_d[i] = wr_data_i;
            end
            for (int n = 0; n < NUM_CH; n++) begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_addr_i == 8'(BASE_ADDR + 4*n + k) || wr_addr_i == ALL_ADDR + 8'(k)) begin
                        led_d[n][k]   = wr_data_i;
                        dirty_d[n][k] = 1'b1;
                    end
                end
            end
        end

        if (rd_addr_i == 8'h00) rd_d = mode1_q;
        if (rd_addr_i == 8'h01) rd_d = mode2_q;
        if (rd_addr_i == PRE_ADDR) rd_d = pre_q;
        for (int i = 0; i < GEN_N; i++) begin
            if (rd_addr_i == 8'(i + 2)) rd_d = gen_q[i];
        end
        for (int n = 0; n < NUM_CH; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (rd_addr_i == 8'(BASE_ADDR + 4*n + k)) rd_d = led_q[n][k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode1_q     <= 8'h11;
            mode2_q     <= 8'h04;
            pre_q       <= PRE_RST;
            commit_q    <= '0;
            rd_q        <= 8'h00;
            stop_pend_q <= 1'b0;
            for (int i = 0; i < GEN_N; i++) gen_q[i] <= 8'h00;
            for (int n = 0; n < NUM_CH; n++) begin
                for (int k = 0; k < 4; k++) led_q[n][k] <= 8'h00;
                dirty_q[n] <= 4'b0000;
                on_q[n]    <= 13'h0000;
                off_q[n]   <= 13'h0000;
            end
        end else begin
            mode1_q     <= mode1_d;
            mode2_q     <= mode2_d;
            pre_q       <= pre_d;
            commit_q    <= commit_d;
            rd_q        <= rd_d;
            stop_pend_q <= stop_pend_d;
            gen_q       <= gen_d;
            led_q       <= led_d;
            dirty_q     <= dirty_d;
            on_q        <= on_d;
            off_q       <= off_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_pack
        assign led_on_o[13*n +: 13]  = on_q[n];
        assign led_off_o[13*n +: 13] = off_q[n];
    end

    assign mode1_o    = mode1_q;
    assign mode2_o    = mode2_q;
    assign prescale_o = pre_q;
    assign commit_o   = commit_q;
    assign rd_data_o  = rd_q;

endmodule
